// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_pkg
// Description : Shared types and constants for the data-cache controller.
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] WORD_ADDR_MASK = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    FILL    = 3'd3,
    WR_REQ  = 3'd4
  } dcache_state_t;

endpackage
`default_nettype wire

// File: rtl/dcache_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module      : dcache_perf_cnt
// Description : Free-running load hit / load miss counters, built only when
//               DCACHE_PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef DCACHE_PERF_CNT_EN
module dcache_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hit_inc,
  input  logic             miss_inc,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_miss_cnt;

  // Counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (hit_inc)
        r_hit_cnt <= r_hit_cnt + CNT_W'(1);
      if (miss_inc)
        r_miss_cnt <= r_miss_cnt + CNT_W'(1);
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;

endmodule
`endif
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dcache_ctrl
// Description : Load-miss handling and write-through store controller between
//               the CPU memory stage and the data cache. Optional performance
//               counters are enabled with the DCACHE_PERF_CNT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_ctrl
  import dcache_pkg::*;
`ifdef DCACHE_PERF_CNT_EN
#(
  parameter int CNT_W = 32
)
`endif
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [DATA_W-1:0] cache_wdata,
  output logic              cache_we,
  input  logic [DATA_W-1:0] cache_rdata,
  input  logic              cache_hit,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
`endif
);

  dcache_state_t     r_state;
  dcache_state_t     w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  // r_data holds store data from IDLE, then fill data once the read returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && cpu_req) begin
        r_addr <= cpu_addr & WORD_ADDR_MASK;
        r_data <= cpu_wdata;
      end else if (r_state == RD_WAIT && mem_resp_valid) begin
        r_data <= mem_resp_rdata;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    cpu_rdata     = '0;
    cpu_stall     = 1'b0;
    cache_addr    = cpu_addr;
    cache_wdata   = '0;
    cache_we      = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;

    case (r_state)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            cpu_stall   = 1'b1;
            w_state_nxt = WR_REQ;
          end else if (cache_hit) begin
            cpu_rdata = cache_rdata;
          end else begin
            cpu_stall   = 1'b1;
            w_state_nxt = RD_REQ;
          end
        end
      end

      RD_REQ: begin
        cpu_stall     = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_addr  = r_addr;
        if (mem_req_ready)
          w_state_nxt = RD_WAIT;
      end

      RD_WAIT: begin
        cpu_stall = 1'b1;
        if (mem_resp_valid)
          w_state_nxt = FILL;
      end

      FILL: begin
        cache_we    = 1'b1;
        cache_addr  = r_addr;
        cache_wdata = r_data;
        cpu_rdata   = r_data;
        w_state_nxt = IDLE;
      end

      WR_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = r_addr;
        mem_req_wdata = r_data;
        cpu_stall     = !mem_req_ready;
        // Cache is only touched once memory has taken the write.
        if (mem_req_ready) begin
          cache_we    = 1'b1;
          cache_addr  = r_addr;
          cache_wdata = r_data;
          w_state_nxt = IDLE;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef DCACHE_PERF_CNT_EN
  logic w_hit_inc;
  logic w_miss_inc;

  assign w_hit_inc  = (r_state == IDLE) && cpu_req && !cpu_we && cache_hit;
  assign w_miss_inc = (r_state == IDLE) && cpu_req && !cpu_we && !cache_hit;

  dcache_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_perf_cnt (
    .clk      (clk),
    .rst      (rst),
    .hit_inc  (w_hit_inc),
    .miss_inc (w_miss_inc),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_ctrl
// Description : Directed and randomized bench for dcache_ctrl with a word-level
//               memory/cache environment and a reference memory image.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic [31:0] cache_addr, cache_wdata, cache_rdata;
  logic        cache_we, cache_hit;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_we(cache_we),
    .cache_rdata(cache_rdata), .cache_hit(cache_hit),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
`ifdef DCACHE_PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  // Word-indexed environment: cache contents, backing memory, reference image.
  bit          cv    [0:16383];
  logic [31:0] cd    [0:16383];
  logic [31:0] mem_m [0:16383];
  logic [31:0] ref_m [0:16383];

  assign cache_hit   = cv[cache_addr[15:2]];
  assign cache_rdata = cd[cache_addr[15:2]];

  int          total = 0;
  int          bad   = 0;
  bit          pending = 1'b0;
  bit          p_fire  = 1'b0;
  logic [13:0] p_idx;
  int          p_dly;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Applies what the DUT did this cycle to the cache/memory environment.
  task automatic env_update();
    if (cache_we) begin
      cv[cache_addr[15:2]] = 1'b1;
      cd[cache_addr[15:2]] = cache_wdata;
    end
    if (p_fire && mem_resp_valid)
      pending = 1'b0;
    p_fire = 1'b0;
    if (mem_req_valid && mem_req_ready) begin
      if (mem_req_we) begin
        mem_m[mem_req_addr[15:2]] = mem_req_wdata;
      end else begin
        pending = 1'b1;
        p_idx   = mem_req_addr[15:2];
        p_dly   = $urandom_range(0, 3);
      end
    end
  endtask

  task automatic tick();
    env_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_mem();
    mem_req_ready = ($urandom_range(0, 2) != 0);
    if (pending && p_dly == 0) begin
      mem_resp_valid = 1'b1;
      mem_resp_rdata = mem_m[p_idx];
      p_fire         = 1'b1;
    end else begin
      mem_resp_valid = !pending && ($urandom_range(0, 5) == 0);
      mem_resp_rdata = $urandom;
      if (pending) p_dly--;
    end
  endtask

  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output int cyc);
    bit          done = 1'b0;
    bit          prev_wait = 1'b0;
    logic [31:0] prev_addr = '0;
    rd = '0;
    cyc = 0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    while (!done) begin
      drive_mem();
      @(negedge clk);
      if (prev_wait) begin
        check("req_valid_hold", {31'b0, mem_req_valid}, 32'd1);
        check("req_addr_hold", mem_req_addr, prev_addr);
      end
      prev_wait = mem_req_valid && !mem_req_ready;
      prev_addr = mem_req_addr;
      if (mem_req_valid) begin
        check("req_addr", mem_req_addr, addr & 32'hFFFF_FFFC);
        check("req_we", {31'b0, mem_req_we}, {31'b0, we});
      end
      if (!cpu_stall) begin
        done = 1'b1;
        rd   = cpu_rdata;
      end
      tick();
      if (!done) begin
        cyc++;
        if (cyc > 60) begin
          check("access_timeout", 32'd1, 32'd0);
          done = 1'b1;
        end
      end
    end
    cpu_req = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, a, wd;
    logic [13:0] idx;
    int          cyc;
    bit          we, was_hit;

    for (int i = 0; i < 16384; i++) begin
      cv[i] = 1'b0; cd[i] = 32'h0BAD_0000 | i; mem_m[i] = '0; ref_m[i] = '0;
    end
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    tick(); tick();
    rst = 1'b0; cpu_addr = 32'h0000_0055;
    @(negedge clk);
    check("rst_stall", {31'b0, cpu_stall}, 32'd0);
    check("rst_valid", {31'b0, mem_req_valid}, 32'd0);
    check("rst_cache_we", {31'b0, cache_we}, 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_cache_addr", cache_addr, 32'h0000_0055);
    check("rst_mem_addr", mem_req_addr, 32'd0);
    tick();

    // Load hit
    cv[32'h40 >> 2] = 1'b1; cd[32'h40 >> 2] = 32'hDEAD_BEEF;
    mem_m[32'h40 >> 2] = 32'hDEAD_BEEF; ref_m[32'h40 >> 2] = 32'hDEAD_BEEF;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    @(negedge clk);
    check("hit_rdata", cpu_rdata, 32'hDEAD_BEEF);
    check("hit_stall", {31'b0, cpu_stall}, 32'd0);
    check("hit_valid", {31'b0, mem_req_valid}, 32'd0);
    tick();

    // Spurious response and ready while idle
    cpu_req = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'hFFFF_0000; mem_req_ready = 1'b1;
    @(negedge clk);
    check("idle_spur_valid", {31'b0, mem_req_valid}, 32'd0);
    check("idle_spur_stall", {31'b0, cpu_stall}, 32'd0);
    tick();
    mem_resp_valid = 1'b0; mem_req_ready = 1'b0;

    // Load miss 0x1004, spurious resp during RD_REQ, resp 3 cycles after handshake
    mem_m[32'h1004 >> 2] = 32'h1234_5678; ref_m[32'h1004 >> 2] = 32'h1234_5678;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1004;
    @(negedge clk);
    check("miss_c0_stall", {31'b0, cpu_stall}, 32'd1);
    check("miss_c0_valid", {31'b0, mem_req_valid}, 32'd0);
    tick();
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hBADB_AD00;
    @(negedge clk);
    check("miss_rdreq_valid", {31'b0, mem_req_valid}, 32'd1);
    check("miss_rdreq_we", {31'b0, mem_req_we}, 32'd0);
    check("miss_rdreq_addr", mem_req_addr, 32'h1004);
    check("miss_rdreq_stall", {31'b0, cpu_stall}, 32'd1);
    tick();
    mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    check("miss_spur_ignored", {31'b0, mem_req_valid}, 32'd1);
    tick();
    mem_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1234_5678; end
      @(negedge clk);
      check("miss_wait_stall", {31'b0, cpu_stall}, 32'd1);
      check("miss_wait_cache_we", {31'b0, cache_we}, 32'd0);
      check("miss_wait_valid", {31'b0, mem_req_valid}, 32'd0);
      tick();
    end
    mem_resp_valid = 1'b0; mem_resp_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("fill_cache_we", {31'b0, cache_we}, 32'd1);
    check("fill_cache_addr", cache_addr, 32'h1004);
    check("fill_cache_wdata", cache_wdata, 32'h1234_5678);
    check("fill_rdata", cpu_rdata, 32'h1234_5678);
    check("fill_stall", {31'b0, cpu_stall}, 32'd0);
    tick();

    // Back-to-back store 0x2000, ready low for two cycles
    cpu_we = 1'b1; cpu_addr = 32'h2000; cpu_wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    check("st_c0_stall", {31'b0, cpu_stall}, 32'd1);
    check("st_c0_cache_we", {31'b0, cache_we}, 32'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      mem_req_ready = (k == 2);
      @(negedge clk);
      check("st_valid", {31'b0, mem_req_valid}, 32'd1);
      check("st_we", {31'b0, mem_req_we}, 32'd1);
      check("st_addr", mem_req_addr, 32'h2000);
      check("st_wdata", mem_req_wdata, 32'hA5A5_A5A5);
      check("st_cache_we", {31'b0, cache_we}, (k == 2) ? 32'd1 : 32'd0);
      check("st_stall", {31'b0, cpu_stall}, (k == 2) ? 32'd0 : 32'd1);
      if (k == 2) begin
        check("st_cache_addr", cache_addr, 32'h2000);
        check("st_cache_wdata", cache_wdata, 32'hA5A5_A5A5);
      end
      tick();
    end
    cpu_req = 1'b0; mem_req_ready = 1'b0;
    ref_m[32'h2000 >> 2] = 32'hA5A5_A5A5;
    @(negedge clk);
    check("st_after_valid", {31'b0, mem_req_valid}, 32'd0);
    check("st_mem_written", mem_m[32'h2000 >> 2], 32'hA5A5_A5A5);
    tick();
    access(1'b0, 32'h2000, '0, rd, cyc);
    check("st_alloc_rdata", rd, 32'hA5A5_A5A5);
    check("st_alloc_hit_lat", cyc, 0);

    // Reset while waiting for a read response
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1100;
    tick();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    @(negedge clk);
    check("rdwait_stall", {31'b0, cpu_stall}, 32'd1);
    tick();
    rst = 1'b1; cpu_req = 1'b0;
    tick();
    rst = 1'b0; pending = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", {31'b0, mem_req_valid}, 32'd0);
    check("rst_mid_stall", {31'b0, cpu_stall}, 32'd0);
    tick();
    access(1'b0, 32'h40, '0, rd, cyc);
    check("rst_mid_hit_rdata", rd, 32'hDEAD_BEEF);
    check("rst_mid_hit_lat", cyc, 0);

    // Randomized traffic over a small word pool against the reference image
    for (int i = 0; i < 8; i++) begin
      mem_m[14'hC00 + i] = $urandom;
      ref_m[14'hC00 + i] = mem_m[14'hC00 + i];
    end
    pending = 1'b0;
    for (int n = 0; n < 80; n++) begin
      a   = 32'h3000 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
      idx = a[15:2];
      we  = ($urandom_range(0, 2) == 0);
      was_hit = cv[idx];
      if (we) begin
        wd = $urandom;
        access(1'b1, a, wd, rd, cyc);
        ref_m[idx] = wd;
        check("rnd_st_lat", {31'b0, cyc >= 1}, 32'd1);
      end else begin
        access(1'b0, a, '0, rd, cyc);
        check("rnd_ld_data", rd, ref_m[idx]);
        if (was_hit) check("rnd_hit_lat", cyc, 0);
        else         check("rnd_miss_lat", {31'b0, cyc >= 3}, 32'd1);
      end
      if ($urandom_range(0, 3) == 0) begin
        drive_mem();
        @(negedge clk);
        check("rnd_idle_valid", {31'b0, mem_req_valid}, 32'd0);
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      end
    end
    for (int i = 0; i < 8; i++) begin
      check("rnd_mem_coherent", mem_m[14'hC00 + i], ref_m[14'hC00 + i]);
      if (cv[14'hC00 + i]) check("rnd_cache_coherent", cd[14'hC00 + i], ref_m[14'hC00 + i]);
    end

    // Counter run: 3 hits, 2 misses, 1 store after a fresh reset
    rst = 1'b1; tick(); rst = 1'b0; pending = 1'b0;
    mem_m[32'h5000 >> 2] = 32'h0000_5000; ref_m[32'h5000 >> 2] = 32'h0000_5000;
    mem_m[32'h5004 >> 2] = 32'h0000_5004; ref_m[32'h5004 >> 2] = 32'h0000_5004;
    for (int k = 0; k < 3; k++) begin
      access(1'b0, 32'h40, '0, rd, cyc);
      check("cnt_hit_rdata", rd, 32'hDEAD_BEEF);
    end
    access(1'b0, 32'h5000, '0, rd, cyc);
    check("cnt_miss0_rdata", rd, 32'h0000_5000);
    access(1'b1, 32'h5008, 32'h77, rd, cyc);
    access(1'b0, 32'h5004, '0, rd, cyc);
    check("cnt_miss1_rdata", rd, 32'h0000_5004);
    @(negedge clk);
`ifdef DCACHE_PERF_CNT_EN
    check("hit_cnt", hit_cnt, 32'd3);
    check("miss_cnt", miss_cnt, 32'd2);
`endif
    check("end_idle_stall", {31'b0, cpu_stall}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
